// File: rtl/cdp_dp_layer_seq.sv
// cdp_dp_layer_seq: CDP input-stage layer sequencer (gate + outstanding).
// Optional per-layer beat/stall statistics: define CDP_LAYER_STAT_EN.
module cdp_dp_layer_seq #(
    parameter int PD_W  = 31,
    parameter int CNT_W = 32
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg2dp_op_en,
    input  logic             dp2reg_done,
    input  logic             in_pvld,
    output logic             in_prdy,
    input  logic [PD_W-1:0]  in_pd,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [PD_W-1:0]  out_pd,
    output logic             dp2reg_layer_busy,
    output logic [1:0]       dp2reg_outstanding,
    output logic [CNT_W-1:0] dp2reg_beat_num,
    output logic [CNT_W-1:0] dp2reg_stall_num
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q;
    logic            start_pend_q;
    logic            op_en_d1_q;
    logic            out_pvld_q;
    logic [PD_W-1:0] out_pd_q;
    logic [1:0]      outstanding_q;
    logic [1:0]      outstanding_d;

    logic op_en_load;
    logic run;
    logic accept;
    logic layer_end;
    logic start_go;
    logic done_vld;

    assign op_en_load = reg2dp_op_en & ~op_en_d1_q;
    assign run        = (state_q == ST_RUN);
    assign in_prdy    = run & (~out_pvld_q | out_prdy);
    assign accept     = in_pvld & in_prdy;
    assign layer_end  = accept & (&in_pd[22:16]);
    assign start_go   = ~run & start_pend_q & (outstanding_q < 2'd2);
    assign done_vld   = dp2reg_done & (outstanding_q != 2'd0);

    assign out_pvld           = out_pvld_q;
    assign out_pd             = out_pd_q;
    assign dp2reg_layer_busy  = run;
    assign dp2reg_outstanding = outstanding_q;

    // Rising-edge detect on the layer enable level
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            op_en_d1_q <= 1'b0;
        end else begin
            op_en_d1_q <= reg2dp_op_en;
        end
    end

    // Layer gate FSM; a pending start is consumed when the gate opens
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            start_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_go) state_q <= ST_RUN;
                ST_RUN:  if (layer_end) state_q <= ST_IDLE;
            endcase
            if (start_go) begin
                start_pend_q <= 1'b0;
            end else if (op_en_load) begin
                start_pend_q <= 1'b1;
            end
        end
    end

    // Output pipe register; keeps draining after the gate closes
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_pvld_q <= 1'b0;
            out_pd_q   <= '0;
        end else if (accept) begin
            out_pvld_q <= 1'b1;
            out_pd_q   <= in_pd;
        end else if (out_prdy) begin
            out_pvld_q <= 1'b0;
        end
    end

    // Ended-but-not-done count; a stray done at zero is dropped
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({layer_end, done_vld})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding layer counter register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            outstanding_q <= 2'd0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

`ifdef CDP_LAYER_STAT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]            beat_cnt_q;
    logic [CNT_W-1:0]            stall_cnt_q;
    logic [CNT_W-1:0]            beat_cnt_d;
    logic [CNT_W-1:0]            stall_cnt_d;
    logic [1:0][CNT_W-1:0]       slot_beat_q;
    logic [1:0][CNT_W-1:0]       slot_stall_q;
    logic                        layer_flag_q;
    logic                        done_flag_q;
    logic [CNT_W-1:0]            beat_num_q;
    logic [CNT_W-1:0]            stall_num_q;
    logic                        stall_hit;

    assign stall_hit = run & out_pvld_q & ~out_prdy;

    // Saturating running totals, including the current cycle's event
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && !(&beat_cnt_q)) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
        if (stall_hit && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Live counters; cleared once a layer's totals are parked
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (layer_end) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Ping-pong parking of finished layers, read back oldest first
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            slot_beat_q  <= '0;
            slot_stall_q <= '0;
            layer_flag_q <= 1'b0;
            done_flag_q  <= 1'b0;
            beat_num_q   <= '0;
            stall_num_q  <= '0;
        end else begin
            if (layer_end) begin
                slot_beat_q[layer_flag_q]  <= beat_cnt_d;
                slot_stall_q[layer_flag_q] <= stall_cnt_d;
                layer_flag_q               <= ~layer_flag_q;
            end
            if (done_vld) begin
                beat_num_q  <= slot_beat_q[done_flag_q];
                stall_num_q <= slot_stall_q[done_flag_q];
                done_flag_q <= ~done_flag_q;
            end
        end
    end

    assign dp2reg_beat_num  = beat_num_q;
    assign dp2reg_stall_num = stall_num_q;
`else
    assign dp2reg_beat_num  = '0;
    assign dp2reg_stall_num = '0;
`endif

endmodule

// File: tb/tb_cdp_dp_layer_seq.sv
// tb_cdp_dp_layer_seq: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cdp_dp_layer_seq;

    localparam int PD_W  = 31;
    localparam int CNT_W = 32;
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;
`ifdef CDP_LAYER_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_en = 1'b0;
    logic             done = 1'b0;
    logic             in_pvld = 1'b0;
    logic             in_prdy;
    logic [PD_W-1:0]  in_pd = '0;
    logic             out_pvld;
    logic             out_prdy = 1'b0;
    logic [PD_W-1:0]  out_pd;
    logic             busy;
    logic [1:0]       outs;
    logic [CNT_W-1:0] bnum;
    logic [CNT_W-1:0] snum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdp_dp_layer_seq #(.PD_W(PD_W), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rst_n),
        .reg2dp_op_en       (op_en),
        .dp2reg_done        (done),
        .in_pvld            (in_pvld),
        .in_prdy            (in_prdy),
        .in_pd              (in_pd),
        .out_pvld           (out_pvld),
        .out_prdy           (out_prdy),
        .out_pd             (out_pd),
        .dp2reg_layer_busy  (busy),
        .dp2reg_outstanding (outs),
        .dp2reg_beat_num    (bnum),
        .dp2reg_stall_num   (snum)
    );

    // reference model: layers as a FIFO of (beats, stalls) records
    bit              m_run, m_pend, m_prev, m_ov;
    bit              m_rdy, m_acc, m_le, m_load, m_go, m_stl;
    int              m_outs;
    logic [PD_W-1:0] m_opd = '0;
    longint          m_beats, m_stalls, m_bnum, m_snum;
    longint          q_beats[$];
    longint          q_stalls[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_prev = 0; m_ov = 0;
            m_outs = 0; m_opd = '0;
            m_beats = 0; m_stalls = 0; m_bnum = 0; m_snum = 0;
            q_beats.delete(); q_stalls.delete();
        end else begin
            m_rdy  = m_run && (!m_ov || out_prdy);
            m_acc  = in_pvld && m_rdy;
            m_le   = m_acc && (in_pd[22:16] == 7'h7F);
            m_load = op_en && !m_prev;
            m_go   = !m_run && m_pend && (m_outs < 2);
            m_stl  = m_run && m_ov && !out_prdy;
            if (m_acc && m_beats < CMAX) m_beats++;
            if (m_stl && m_stalls < CMAX) m_stalls++;
            if (done && m_outs > 0) begin
                m_bnum = q_beats.pop_front();
                m_snum = q_stalls.pop_front();
                m_outs--;
            end
            if (m_le) begin
                q_beats.push_back(m_beats);
                q_stalls.push_back(m_stalls);
                m_beats = 0; m_stalls = 0;
                m_outs++;
            end
            if (m_acc) begin
                m_ov = 1; m_opd = in_pd;
            end else if (out_prdy) begin
                m_ov = 0;
            end
            if (m_go) m_run = 1;
            else if (m_le) m_run = 0;
            if (m_go) m_pend = 0;
            else if (m_load) m_pend = 1;
            m_prev = op_en;
        end
    end

    function automatic logic [PD_W-1:0] mk_pd(input bit last);
        logic [PD_W-1:0] p;
        p = PD_W'($urandom);
        if (last) p[22:16] = 7'h7F;
        else p[16] = 1'b0;
        return p;
    endfunction

    task automatic pulse_done();
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    task automatic send_layer(input int n, output bit ok);
        int sent = 0;
        int guard = 0;
        @(negedge clk); op_en = 1'b0; out_prdy = 1'b1;
        @(negedge clk); op_en = 1'b1;
        while (sent < n && guard < 200) begin
            @(negedge clk);
            in_pvld = 1'b1;
            in_pd = mk_pd(sent == n - 1);
            #1;
            if (in_prdy) sent++;
            guard++;
        end
        @(negedge clk); in_pvld = 1'b0;
        ok = (sent == n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_pvld = 1'b1; in_pd = mk_pd(1'b1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({in_prdy, out_pvld, busy, outs} !== 5'b0 || out_pd !== '0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b/%h want 0", {in_prdy, out_pvld, busy, outs}, out_pd);
        end
        n_cmp++;
        if (bnum !== '0 || snum !== '0) begin
            n_err++;
            $display("FAIL reset_stat: got %0d/%0d want 0/0", bnum, snum);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_pvld = 1'b1;
            in_pd = mk_pd(i[0]);
            #1;
            n_cmp++;
            if (in_prdy !== 1'b0 || out_pvld !== 1'b0) begin
                n_err++;
                $display("FAIL idle_gate c%0d: got %b%b want 00", i, in_prdy, out_pvld);
            end
        end
        @(negedge clk); in_pvld = 1'b0;
    endtask

    task automatic test_single_layer();
        logic [PD_W-1:0] b [5];
        for (int i = 0; i < 5; i++) b[i] = mk_pd(i == 4);
        out_prdy = 1'b1;
        @(negedge clk); op_en = 1'b1; #1;
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, in_prdy} !== 2'b00) begin
            n_err++;
            $display("FAIL start_t1: got %b want 00", {busy, in_prdy});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); in_pvld = 1'b1; in_pd = b[i]; #1;
            n_cmp++;
            if ({busy, in_prdy} !== 2'b11) begin
                n_err++;
                $display("FAIL run_b%0d: got %b want 11", i, {busy, in_prdy});
            end
            if (i > 0) begin
                n_cmp++;
                if (out_pvld !== 1'b1 || out_pd !== b[i-1]) begin
                    n_err++;
                    $display("FAIL out_b%0d: got %b %h want 1 %h", i - 1, out_pvld, out_pd, b[i-1]);
                end
            end
        end
        @(negedge clk); in_pvld = 1'b0; #1;
        n_cmp++;
        if ({busy, in_prdy, out_pvld, outs} !== 5'b00101 || out_pd !== b[4]) begin
            n_err++;
            $display("FAIL end_state: got %b %h want 00101 %h", {busy, in_prdy, out_pvld, outs}, out_pd, b[4]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_pvld !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %b want 0", out_pvld);
        end
        pulse_done(); #1;
        n_cmp++;
        if (outs !== 2'd0 || bnum !== (STAT ? 32'd5 : 32'd0) || snum !== '0) begin
            n_err++;
            $display("FAIL single_stat: got %0d %0d %0d want 0 %0d 0", outs, bnum, snum, STAT ? 5 : 0);
        end
    endtask

    task automatic test_stall();
        logic [PD_W-1:0] b0, b1;
        b0 = mk_pd(1'b0); b1 = mk_pd(1'b0);
        @(negedge clk); op_en = 1'b0;
        @(negedge clk); op_en = 1'b1; out_prdy = 1'b1;
        @(negedge clk);
        @(negedge clk); in_pvld = 1'b1; in_pd = b0; #1;
        n_cmp++;
        if (in_prdy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_start: got %b want 1", in_prdy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_pd = b1; out_prdy = 1'b0; #1;
            n_cmp++;
            if (in_prdy !== 1'b0 || out_pvld !== 1'b1 || out_pd !== b0) begin
                n_err++;
                $display("FAIL stall_c%0d: got %b%b %h want 01 %h", i, in_prdy, out_pvld, out_pd, b0);
            end
        end
        @(negedge clk); out_prdy = 1'b1; #1;
        n_cmp++;
        if (in_prdy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got %b want 1", in_prdy);
        end
        @(negedge clk); in_pd = mk_pd(1'b1); #1;
        n_cmp++;
        if (in_prdy !== 1'b1 || out_pd !== b1) begin
            n_err++;
            $display("FAIL stall_next: got %b %h want 1 %h", in_prdy, out_pd, b1);
        end
        @(negedge clk); in_pvld = 1'b0;
        pulse_done(); #1;
        n_cmp++;
        if (bnum !== (STAT ? 32'd3 : 32'd0) || snum !== (STAT ? 32'd3 : 32'd0)) begin
            n_err++;
            $display("FAIL stall_stat: got %0d/%0d want %0d/%0d", bnum, snum, STAT ? 3 : 0, STAT ? 3 : 0);
        end
    endtask

    task automatic test_three_layers();
        bit ok1, ok2;
        send_layer(1, ok1);
        send_layer(1, ok2);
        n_cmp++;
        if (!ok1 || !ok2 || outs !== 2'd2) begin
            n_err++;
            $display("FAIL two_layers: got ok %b%b outs %0d want 11 2", ok1, ok2, outs);
        end
        @(negedge clk); op_en = 1'b0;
        @(negedge clk); op_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_pvld = 1'b1; in_pd = mk_pd(1'b1); #1;
            n_cmp++;
            if ({busy, in_prdy, outs} !== 4'b0010) begin
                n_err++;
                $display("FAIL blocked_c%0d: got %b want 0010", i, {busy, in_prdy, outs});
            end
        end
        @(negedge clk); done = 1'b1; #1;
        @(negedge clk); done = 1'b0; #1;
        n_cmp++;
        if ({busy, outs} !== 3'b001) begin
            n_err++;
            $display("FAIL unblock_t1: got %b want 001", {busy, outs});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, in_prdy} !== 2'b11) begin
            n_err++;
            $display("FAIL unblock_t2: got %b want 11", {busy, in_prdy});
        end
        @(negedge clk); in_pvld = 1'b0; #1;
        n_cmp++;
        if ({busy, outs} !== 3'b010) begin
            n_err++;
            $display("FAIL third_end: got %b want 010", {busy, outs});
        end
        pulse_done();
        pulse_done(); #1;
        n_cmp++;
        if (outs !== 2'd0 || bnum !== (STAT ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL three_drain: got %0d %0d want 0 %0d", outs, bnum, STAT ? 1 : 0);
        end
    endtask

    task automatic test_coincident();
        @(negedge clk); op_en = 1'b0; out_prdy = 1'b1;
        @(negedge clk); op_en = 1'b1;
        @(negedge clk); op_en = 1'b0;
        @(negedge clk); in_pvld = 1'b1; in_pd = mk_pd(1'b0); #1;
        @(negedge clk); in_pd = mk_pd(1'b1); op_en = 1'b1; #1;
        n_cmp++;
        if ({busy, in_prdy} !== 2'b11) begin
            n_err++;
            $display("FAIL coin_end: got %b want 11", {busy, in_prdy});
        end
        @(negedge clk); in_pvld = 1'b0; #1;
        n_cmp++;
        if ({busy, outs} !== 3'b001) begin
            n_err++;
            $display("FAIL coin_t1: got %b want 001", {busy, outs});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, in_prdy} !== 2'b11) begin
            n_err++;
            $display("FAIL coin_t2: got %b want 11", {busy, in_prdy});
        end
        @(negedge clk); in_pvld = 1'b1; in_pd = mk_pd(1'b1); done = 1'b1; #1;
        @(negedge clk); in_pvld = 1'b0; done = 1'b0; #1;
        n_cmp++;
        if ({busy, outs} !== 3'b001 || bnum !== (STAT ? 32'd2 : 32'd0)) begin
            n_err++;
            $display("FAIL done_and_end: got %b %0d want 001 %0d", {busy, outs}, bnum, STAT ? 2 : 0);
        end
        pulse_done();
        pulse_done(); #1;
        n_cmp++;
        if (outs !== 2'd0 || bnum !== (STAT ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL done_at_zero: got %0d %0d want 0 %0d", outs, bnum, STAT ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); op_en = 1'b0; out_prdy = 1'b1;
        @(negedge clk); op_en = 1'b1;
        @(negedge clk);
        @(negedge clk); in_pvld = 1'b1; in_pd = mk_pd(1'b0); out_prdy = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({out_pvld, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset: got %b want 11", {out_pvld, busy});
        end
        #2 rst_n = 1'b0; op_en = 1'b0; #1;
        n_cmp++;
        if ({in_prdy, out_pvld, busy, outs} !== 5'b0 || out_pd !== '0 || bnum !== '0 || snum !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %b %h %0d %0d want 0", {in_prdy, out_pvld, busy, outs}, out_pd, bnum, snum);
        end
        @(negedge clk); rst_n = 1'b1; out_prdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({busy, in_prdy, out_pvld} !== 3'b000) begin
                n_err++;
                $display("FAIL no_restart_c%0d: got %b want 000", i, {busy, in_prdy, out_pvld});
            end
        end
        @(negedge clk); op_en = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, in_prdy} !== 2'b11) begin
            n_err++;
            $display("FAIL restart: got %b want 11", {busy, in_prdy});
        end
        @(negedge clk); in_pd = mk_pd(1'b1);
        @(negedge clk); in_pvld = 1'b0;
        pulse_done();
    endtask

    task automatic test_random();
        logic exp_prdy;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) op_en = ~op_en;
            in_pvld  = ($urandom_range(0, 9) < 7);
            in_pd    = mk_pd($urandom_range(0, 5) == 0);
            out_prdy = ($urandom_range(0, 9) < 7);
            done     = ($urandom_range(0, 7) == 0);
            #1;
            exp_prdy = m_run && (!m_ov || out_prdy);
            n_cmp++;
            if ({in_prdy, out_pvld, busy, outs} !== {exp_prdy, m_ov, m_run, 2'(m_outs)}) begin
                n_err++;
                $display("FAIL rnd_ctl c%0d: got %b want %b", i, {in_prdy, out_pvld, busy, outs}, {exp_prdy, m_ov, m_run, 2'(m_outs)});
            end
            n_cmp++;
            if (out_pd !== m_opd) begin
                n_err++;
                $display("FAIL rnd_pd c%0d: got %h want %h", i, out_pd, m_opd);
            end
            n_cmp++;
            if (bnum !== (STAT ? CNT_W'(m_bnum) : '0) || snum !== (STAT ? CNT_W'(m_snum) : '0)) begin
                n_err++;
                $display("FAIL rnd_stat c%0d: got %0d/%0d want %0d/%0d", i, bnum, snum, STAT ? m_bnum : 0, STAT ? m_snum : 0);
            end
        end
        @(negedge clk); in_pvld = 1'b0; done = 1'b0; out_prdy = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_layer();
        test_stall();
        test_three_layers();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdp_dp_layer_seq.md
# cdp_dp_layer_seq

Layer sequencer for the CDP datapath input stage. Sits between the CDP RDMA output stream and the NaN/preprocess pipeline. Admits exactly one layer's beats per `reg2dp_op_en` rising edge and closes the gate on the layer-end beat. Tracks layers that have ended but not yet completed (`dp2reg_done`), and stalls new layers while two are outstanding. Optionally keeps per-layer beat/stall statistics with ping-pong latching for `dp2reg`.

## Interface
Parameters:
- `PD_W`, 31, stream payload width. Layer-end flag bits are `pd[22:16]`, all set on the final beat.
- `CNT_W`, 32, statistics counter width.

Ports:
- `nvdla_core_clk` in 1: sole clock.
- `nvdla_core_rstn` in 1: reset, asynchronous assert, active-low.
- `reg2dp_op_en` in 1: layer enable level; a rising edge requests one layer.
- `dp2reg_done` in 1: single-cycle pulse, oldest outstanding layer complete.
- `in_pvld` in 1: RDMA stream valid.
- `in_prdy` out 1: RDMA stream ready.
- `in_pd` in PD_W: RDMA payload.
- `out_pvld` out 1: downstream valid.
- `out_prdy` in 1: downstream ready.
- `out_pd` out PD_W: registered payload.
- `dp2reg_layer_busy` out 1: state is RUN.
- `dp2reg_outstanding` out 2: ended-but-not-done layers, 0..2.
- `dp2reg_beat_num` out CNT_W: beats of the completed layer (statistics build only, else 0).
- `dp2reg_stall_num` out CNT_W: output-stall cycles of the completed layer (statistics build only, else 0).

## Operation
- Edge detect: `op_en_d1` registers `reg2dp_op_en`. `op_en_load = reg2dp_op_en & ~op_en_d1`.
- `start_pend` flag: set on `op_en_load`, cleared when IDLE→RUN is taken. A second edge while the flag is set is absorbed; the queue depth is 1.
- FSM, two states:
  - IDLE→RUN when `start_pend & (outstanding < 2)`.
  - RUN→IDLE on `layer_end = in_pvld & in_prdy & (&in_pd[22:16])`.
- `in_prdy = (state==RUN) & (~out_pvld | out_prdy)`.
- Output register: load `out_pd` on accept. `out_pvld` is set on accept and cleared on `out_prdy` with no accept.
- `out_pd` and `out_pvld` drain normally after the FSM returns to IDLE.
- `outstanding`: +1 on `layer_end`, −1 on `dp2reg_done`. A simultaneous +1 and −1 leaves it unchanged.
- `dp2reg_done` with `outstanding==0` is ignored; the counter saturates at 0.
- `layer_end` when `outstanding==2` cannot occur, because the start is blocked.

## Timing
- Reset values:
  - state IDLE; `in_prdy` 0, `out_pvld` 0, `out_pd` 0.
  - `start_pend` 0, `op_en_d1` 0, `outstanding` 0.
  - all counters and latches 0; `dp2reg_*` 0.
- `reg2dp_op_en` rises in cycle t: `start_pend`=1 at t+1, RUN at t+2 (if `outstanding<2`), first `in_prdy` at t+2.
- `layer_end` accepted at t: IDLE and `in_prdy`=0 at t+1; `out_pvld` with the last beat at t+1.
- `layer_end` and `op_en_load` in the same cycle t: IDLE at t+1 with `start_pend`=1, RUN at t+2 if `outstanding` (already incremented) < 2.
- `in_pd` to `out_pd` latency is 1 cycle. With `out_prdy` held high, throughput is one beat per cycle.
- Reset mid-layer: immediate return to the reset state; partial beats are discarded.

## Configuration
- `CDP_LAYER_STAT_EN` defined:
  - `beat_cnt` (+1 per accept) and `stall_cnt` (+1 per cycle with `out_pvld & ~out_prdy` in RUN) run; both saturate at all-ones.
  - On `layer_end`, the final values (including that beat) go to slot[`layer_flag`], the counters clear, and `layer_flag` toggles.
  - On `dp2reg_done` with `outstanding>0`, slot[`done_flag`] drives `dp2reg_beat_num`/`dp2reg_stall_num` from the next cycle, and `done_flag` toggles.
- `CDP_LAYER_STAT_EN` undefined:
  - counters, slots and flags are not built; `dp2reg_beat_num`/`dp2reg_stall_num` are tied to 0.

## Test plan
- Reset, then no `op_en` edge, with `in_pvld` high for 20 cycles → `in_prdy` stays 0, `out_pvld` stays 0.
- `op_en` edge; 5 beats, the 5th with `pd[22:16]=7'h7F`; `out_prdy`=1 → 5 beats out, last at accept+1. FSM IDLE after the 5th beat; `outstanding`=1. Stat build: after `dp2reg_done`, `beat_num`=5, `stall_num`=0.
- Three layers started back-to-back without `dp2reg_done` → the third start is blocked in IDLE with `outstanding`=2. One `done` pulse → RUN 2 cycles later.
- `out_prdy` held 0 for 3 cycles with a beat pending → `in_prdy`=0, `out_pd` stable, `stall_num`=3 for that layer.
- `layer_end` and `op_en` edge in the same cycle → IDLE one cycle, RUN at t+2. `dp2reg_done` and `layer_end` in the same cycle → `outstanding` unchanged.
- `nvdla_core_rstn` asserted mid-layer with `out_pvld`=1 → all outputs 0 asynchronously, and `op_en` is required again to restart.
